// File: rtl/piso_serial_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, WIDTH data bits, optional parity, stop bit.
// Optional even-parity bit is enabled by defining PISO_SERIAL_TX_PARITY_EN.
module piso_serial_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PISO_SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             ser_out_d, ser_frame_d, done_d;
  logic             xfer;
`ifdef PISO_SERIAL_TX_PARITY_EN
  logic             par, par_d;
`endif

  assign load_ready = (state == IDLE) || (state == STOP);
  assign busy       = (state != IDLE);
  assign xfer       = load_valid && load_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (xfer) next_state = START;
      START: next_state = DATA;
      DATA:
        if (cnt == LAST) begin
`ifdef PISO_SERIAL_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
`ifdef PISO_SERIAL_TX_PARITY_EN
      PARITY: next_state = STOP;
`endif
      STOP:  next_state = xfer ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: computes what the line carries in the next state so ser_out is a flop.
  always_comb begin
    sreg_d = sreg;
    cnt_d  = cnt;
`ifdef PISO_SERIAL_TX_PARITY_EN
    par_d  = par;
`endif
    if (xfer) begin
      sreg_d = load_data;
      cnt_d  = '0;
`ifdef PISO_SERIAL_TX_PARITY_EN
      par_d  = ^load_data;
`endif
    end else if (state == DATA) begin
      sreg_d = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
      cnt_d  = cnt + CW'(1);
    end

    ser_out_d   = 1'b1;
    ser_frame_d = 1'b0;
    done_d      = 1'b0;
    unique case (next_state)
      IDLE:  ser_out_d = 1'b1;
      START: ser_out_d = 1'b0;
      DATA: begin
        ser_out_d   = MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0];
        ser_frame_d = 1'b1;
      end
`ifdef PISO_SERIAL_TX_PARITY_EN
      PARITY: begin
        ser_out_d   = par;
        ser_frame_d = 1'b1;
      end
`endif
      STOP: begin
        ser_out_d = 1'b1;
        done_d    = 1'b1;
      end
      default: ser_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg      <= '0;
      cnt       <= '0;
      ser_out   <= 1'b1;
      ser_frame <= 1'b0;
      done      <= 1'b0;
`ifdef PISO_SERIAL_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      sreg      <= sreg_d;
      cnt       <= cnt_d;
      ser_out   <= ser_out_d;
      ser_frame <= ser_frame_d;
      done      <= done_d;
`ifdef PISO_SERIAL_TX_PARITY_EN
      par       <= par_d;
`endif
    end
  end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
- Parallel-in, serial-out framed transmitter. It is the transmit-side counterpart to the team's parallel capture registers.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock.
- Each frame is wrapped in a start bit and a stop bit, so a downstream SIPO receiver can resynchronise.
- Sits between a parallel data source and a single-wire serial link.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..32.
- MSB_FIRST, 0, 0 = transmit D[0] first; 1 = transmit D[WIDTH-1] first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load_data  input  WIDTH  parallel word to transmit.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  transmitter can accept a word this cycle.
- ser_out  output  1  registered serial line; idles high.
- ser_frame  output  1  high while ser_out carries a data bit (or the parity bit).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse during the stop-bit cycle.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: state=IDLE, ser_out=1, ser_frame=0, busy=0, done=0, shift register=0, bit counter=0.
- Handshake:
  - A transfer occurs on any rising edge where load_valid && load_ready.
  - load_ready is decoded combinationally from state: 1 in IDLE and in STOP, 0 otherwise.
  - load_valid while load_ready=0 is ignored; the data is not queued.
- States: IDLE, START, DATA, PARITY (PARITY only with the feature enabled), STOP.
- IDLE:
  - ser_out=1.
  - On transfer: capture load_data into the shift register, clear the bit counter, go to START.
- START (1 cycle): ser_out=0, ser_frame=0. Next state is DATA.
- DATA (WIDTH cycles):
  - ser_out = current bit; ser_frame=1.
  - Shift right if MSB_FIRST=0, shift left if MSB_FIRST=1.
  - Counter increments each cycle.
  - When counter==WIDTH-1, go to PARITY if enabled, else STOP.
- STOP (1 cycle):
  - ser_out=1, ser_frame=0, done=1.
  - If a transfer occurs this cycle, go to START (back-to-back, no idle gap). Otherwise go to IDLE.
- Timing:
  - Latency: handshake edge at cycle N puts the start bit on ser_out in cycle N+1. The first data bit appears in cycle N+2.
  - Frame length is WIDTH+2 cycles (WIDTH+3 with parity).
  - Sustained throughput is one word per frame length.
- Captured data is held internally. load_data may change freely after the handshake edge.
- Reset mid-frame: on the next edge, return to reset values. The line goes high, the frame is truncated, done is not pulsed, and the captured word is discarded.
- reset and load_valid asserted together: reset wins and nothing is captured.

Optional Feature:
- Macro: PISO_SERIAL_TX_PARITY_EN.
- Defined:
  - Adds the PARITY state (1 cycle) between DATA and STOP.
  - ser_out = even parity, i.e. the XOR of all WIDTH captured bits, computed at capture; ser_frame=1.
  - Frame length becomes WIDTH+3.
- Undefined:
  - No PARITY state and no parity logic.
  - DATA goes directly to STOP.

Test Plan:
- Reset, then idle 5 cycles -> ser_out=1, busy=0, load_ready=1, done=0 throughout.
- WIDTH=4, MSB_FIRST=0, load 4'b1011 in IDLE:
  - ser_out over the next 6 cycles = 0,1,1,0,1,1.
  - ser_frame=1 only on cycles 2-5.
  - done=1 on cycle 6 only, then IDLE.
- MSB_FIRST=1, load 4'b1011 -> ser_out = 0,1,0,1,1,1.
- Back-to-back: load 4'hA, then hold load_valid with 4'h5 so it is accepted in STOP:
  - Second start bit immediately follows the stop bit.
  - Stream = 0,0,1,0,1,1, 0,1,0,1,0,1.
  - load_valid pulsed during DATA with 4'hF is ignored.
- Reset asserted in the 2nd data cycle of 4'b1011 -> the next cycle has ser_out=1, busy=0, no done pulse. A following load of 4'b0001 transmits cleanly as 0,1,0,0,0,1.
- PISO_SERIAL_TX_PARITY_EN defined, load 4'b1011 -> 0,1,1,0,1,1(parity),1(stop). done is on the 7th cycle.
